// File: rtl/csa_accum_ctrl.sv
// Variable-length multi-operand adder: operands fold into a carry-save (sum, carry) pair,
// resolved by a single carry-propagate add once the last operand has been accepted.
//   state   | meaning
//   IDLE    | waiting for the first operand of a transaction
//   ACCUM   | folding operands into the sum/carry pair
//   RESOLVE | one carry-propagate add into the result registers
//   DONE    | result presented until the consumer takes it
module csa_accum_ctrl #(
    parameter int WIDTH   = 4,
    parameter int MAX_OPS = 16,
    parameter int ACC_W   = WIDTH + $clog2(MAX_OPS),
    parameter int CNT_W   = $clog2(MAX_OPS + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_data,
    input  logic             i_in_last,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [ACC_W-1:0] o_out_sum,
    output logic [CNT_W-1:0] o_out_count,
    output logic             o_overflow
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ACCUM   = 2'd1;
    localparam logic [1:0] S_RESOLVE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]       r_state;
    logic [ACC_W-1:0] r_s;
    logic [ACC_W-1:0] r_c;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic [ACC_W-1:0] r_out_sum;
    logic [CNT_W-1:0] r_out_count;
    logic             r_out_ovf;

    logic             w_accept;
    logic [ACC_W-1:0] w_x;
    logic [ACC_W-1:0] w_maj;

    assign o_in_ready  = (r_state == S_IDLE) || (r_state == S_ACCUM);
    assign o_out_valid = (r_state == S_DONE);
    assign o_out_sum   = r_out_sum;
    assign o_out_count = r_out_count;
    assign o_overflow  = r_out_ovf;

    assign w_accept = i_in_valid & o_in_ready;
    assign w_x      = {{(ACC_W - WIDTH){1'b0}}, i_in_data};
    assign w_maj    = (r_s & r_c) | (r_s & w_x) | (r_c & w_x);

    // The sticky overflow is tracked internally per transaction and copied out at RESOLVE,
    // so the reported flag holds with the rest of the result after DONE clears the tracker.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_s         <= '0;
            r_c         <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_out_sum   <= '0;
            r_out_count <= '0;
            r_out_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_ACCUM: begin
                    if (w_accept) begin
                        r_s <= r_s ^ r_c ^ w_x;
                        r_c <= w_maj << 1;
                        if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_W'(MAX_OPS)) r_ovf <= 1'b1;
                        r_state <= i_in_last ? S_RESOLVE : S_ACCUM;
                    end
                end
                S_RESOLVE: begin
                    r_out_sum   <= r_s + r_c;
                    r_out_count <= r_cnt;
                    r_out_ovf   <= r_ovf;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (i_out_ready) begin
                        r_s     <= '0;
                        r_c     <= '0;
                        r_cnt   <= '0;
                        r_ovf   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Directed bench for csa_accum_ctrl: table of whole transactions plus hand-written
// sequences for consumer back-pressure and mid-transaction reset.
module tb_csa_accum_ctrl;
    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic [4:0] out_count;
    logic       overflow;

    int n_cmp = 0;
    int n_bad = 0;

    csa_accum_ctrl #(.WIDTH(4), .MAX_OPS(16)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_in_valid (in_valid),
        .o_in_ready (in_ready),
        .i_in_data  (in_data),
        .i_in_last  (in_last),
        .o_out_valid(out_valid),
        .i_out_ready(out_ready),
        .o_out_sum  (out_sum),
        .o_out_count(out_count),
        .o_overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [19:0][3:0] ops;
        logic [19:0]      gaps;
        logic [4:0]       n;
        logic [7:0]       exp_sum;
        logic [4:0]       exp_cnt;
        logic             exp_ovf;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic beat(input logic [3:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_vec(input int k);
        vec_t v;
        v = vecs[k];
        for (int b = 0; b < int'(v.n); b++) begin
            if (v.gaps[b]) begin
                // gap cycle with a stray in_last that must be ignored
                in_valid = 1'b0;
                in_last  = 1'b1;
                in_data  = 4'hA;
                tick();
                chk($sformatf("v%0d_gap_ready", k), 32'(in_ready), 32'd1);
            end
            chk($sformatf("v%0d_ready_b%0d", k, b), 32'(in_ready), 32'd1);
            beat(v.ops[b], (b == int'(v.n) - 1));
        end
        chk($sformatf("v%0d_resolve_valid", k), 32'(out_valid), 32'd0);
        chk($sformatf("v%0d_resolve_ready", k), 32'(in_ready), 32'd0);
        tick();
        chk($sformatf("v%0d_done_valid", k), 32'(out_valid), 32'd1);
        chk($sformatf("v%0d_done_ready", k), 32'(in_ready), 32'd0);
        chk($sformatf("v%0d_sum", k), 32'(out_sum), 32'(v.exp_sum));
        chk($sformatf("v%0d_count", k), 32'(out_count), 32'(v.exp_cnt));
        chk($sformatf("v%0d_ovf", k), 32'(overflow), 32'(v.exp_ovf));
        tick();
        chk($sformatf("v%0d_idle_ready", k), 32'(in_ready), 32'd1);
        chk($sformatf("v%0d_idle_valid", k), 32'(out_valid), 32'd0);
    endtask

    initial begin
        vecs[0] = '{ops: 80'hFFFF, gaps: 20'h0, n: 5'd4,
                    exp_sum: 8'd60, exp_cnt: 5'd4, exp_ovf: 1'b0};
        vecs[1] = '{ops: 80'h9, gaps: 20'h0, n: 5'd1,
                    exp_sum: 8'd9, exp_cnt: 5'd1, exp_ovf: 1'b0};
        vecs[2] = '{ops: 80'h0000_FFFF_FFFF_FFFF_FFFF, gaps: 20'h00862, n: 5'd16,
                    exp_sum: 8'd240, exp_cnt: 5'd16, exp_ovf: 1'b0};
        vecs[3] = '{ops: 80'h000F_FFFF_FFFF_FFFF_FFFF, gaps: 20'h10001, n: 5'd17,
                    exp_sum: 8'd255, exp_cnt: 5'd17, exp_ovf: 1'b1};
        vecs[4] = '{ops: 80'h43, gaps: 20'h0, n: 5'd2,
                    exp_sum: 8'd7, exp_cnt: 5'd2, exp_ovf: 1'b0};
        vecs[5] = '{ops: 80'h8765_4321, gaps: 20'h00004, n: 5'd8,
                    exp_sum: 8'd36, exp_cnt: 5'd8, exp_ovf: 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 4'h0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum", 32'(out_sum), 32'd0);
        chk("rst_out_count", 32'(out_count), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);

        for (int k = 0; k < 6; k++) run_vec(k);

        // consumer holds off for 5 cycles in DONE
        out_ready = 1'b0;
        beat(4'd2, 1'b0);
        beat(4'd3, 1'b1);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_sum", 32'(out_sum), 32'd5);
            chk("bp_ready", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        chk("bp_hold_sum", 32'(out_sum), 32'd5);
        chk("bp_hold_count", 32'(out_count), 32'd2);

        // reset in the middle of a transaction discards the partial sum
        beat(4'd1, 1'b0);
        beat(4'd2, 1'b0);
        beat(4'd3, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_in_ready", 32'(in_ready), 32'd1);
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_out_sum", 32'(out_sum), 32'd0);
        beat(4'd5, 1'b1);
        tick();
        chk("mrst_valid", 32'(out_valid), 32'd1);
        chk("mrst_sum", 32'(out_sum), 32'd5);
        chk("mrst_count", 32'(out_count), 32'd1);
        chk("mrst_ovf", 32'(overflow), 32'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
